exmem_reg: RTL and testbench
============================

Name: exmem_reg

Overview:
Pipeline register between the last execute stage (exec3) and the memory stage. It captures exec3's ALU result, zero/overflow flags, branch target and destination register, together with the control bits carried down the pipe. It resolves taken branches into a one-cycle PC-redirect pulse and converts arithmetic overflow into a precise exception with a held EPC. It supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
REG_SIZE, 32, data/ALU result width (matches `REG_SIZE)
ADDR_SIZE, 32, PC width (matches `ADDR_SIZE)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  exec3 output holds a real instruction
in_aluresult  in  REG_SIZE  ALU result from exec3
in_zero  in  1  zero flag from exec3
in_overflow  in  1  overflow flag from exec3
in_new_pc  in  ADDR_SIZE  branch target from exec3
in_pc  in  ADDR_SIZE  PC of the instruction in exec3
in_dst  in  5  destination register from exec3
in_regwrite, in_memread, in_memwrite, in_branch  in  1 each  control bits
in_store_data  in  REG_SIZE  rs2 value for stores
stall  in  1  memory stage busy; hold contents
flush  in  1  squash the instruction being captured
exc_ack  in  1  exception handler has taken EPC
out_valid  out  1  register holds a real instruction
out_aluresult  out  REG_SIZE  registered ALU result (memory address or writeback value)
out_store_data  out  REG_SIZE  registered store data
out_dst  out  5  registered destination
out_regwrite, out_memread, out_memwrite  out  1 each  registered, qualified control
redirect  out  1  one-cycle pulse: taken branch
redirect_pc  out  ADDR_SIZE  target for redirect
exc_pending  out  1  overflow exception outstanding
epc  out  ADDR_SIZE  PC of the faulting instruction

Behaviour:
- Reset (reset=1 at edge) clears every output to 0, including epc and redirect_pc. Reset overrides stall, flush and exc_ack.
- Latency: 1 cycle. Input values at edge N appear on the outputs after edge N.
- Priority at each edge, highest first: reset, then flush, then stall, then capture.
- Capture with eff_valid = in_valid & ~exc_pending:
  - out_valid = eff_valid; data fields copied.
  - out_regwrite = in_regwrite & eff_valid & ~in_overflow.
  - out_memread = in_memread & eff_valid & ~in_overflow.
  - out_memwrite = in_memwrite & eff_valid & ~in_overflow.
- Flush: out_valid and all out_* control bits become 0. Data fields are don't-care and are held. redirect stays 0.
- Stall: all out_* fields hold, and redirect is forced to 0. The instruction is never re-issued as a second redirect.
- Branch: on capture with eff_valid & in_branch & in_zero, redirect=1 for exactly one cycle and redirect_pc=in_new_pc. redirect_pc holds its value otherwise.
- Exception FSM, states IDLE and PEND:
  - IDLE→PEND on capture of eff_valid & in_overflow. At the same time epc=in_pc and exc_pending=1.
  - In PEND, all new instructions are captured as bubbles, regardless of in_valid. epc holds.
  - PEND→IDLE on exc_ack. exc_pending clears at that edge, and the same edge may capture a valid instruction.
  - exc_ack in IDLE is ignored.
  - Overflow with flush or stall asserted in the same cycle does not raise an exception; the instruction is squashed or not yet captured.
  - Overflow together with a taken branch: the exception wins, and redirect is suppressed.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset, then in_valid=1, aluresult=0x0000_1234, dst=5, regwrite=1 → next cycle out_valid=1, out_aluresult=0x1234, out_dst=5, out_regwrite=1.
2. Branch with zero=1, new_pc=0x0000_0040, stall=0 → redirect=1 for one cycle with redirect_pc=0x40. Repeat with zero=0 → redirect stays 0.
3. Capture, then stall=1 for 3 cycles with changing inputs → outputs frozen, redirect=0 throughout. Release stall → new input captured next cycle.
4. flush=1 with in_valid=1, regwrite=1, memwrite=1 → out_valid=0, out_regwrite=0, out_memwrite=0, and no redirect even if branch & zero.
5. Overflow with in_pc=0x0000_0100 and regwrite=1 → out_regwrite=0, exc_pending=1, epc=0x100. Following valid instructions produce out_valid=0 until exc_ack. After ack, the next instruction is captured normally and epc holds 0x100.
6. reset asserted while exc_pending=1 and stall=1 → next cycle all outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/exmem_reg.sv
// EX3->MEM pipeline register with branch-redirect pulse and precise overflow exception.
// Latency: 1 cycle, registered outputs only, no combinational input->output path.
// Backpressure: stall holds every field and masks redirect; flush inserts a bubble.
module exmem_reg #(
    parameter int REG_SIZE  = 32,
    parameter int ADDR_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [REG_SIZE-1:0]  in_aluresult,
    input  logic                 in_zero,
    input  logic                 in_overflow,
    input  logic [ADDR_SIZE-1:0] in_new_pc,
    input  logic [ADDR_SIZE-1:0] in_pc,
    input  logic [4:0]           in_dst,
    input  logic                 in_regwrite,
    input  logic                 in_memread,
    input  logic                 in_memwrite,
    input  logic                 in_branch,
    input  logic [REG_SIZE-1:0]  in_store_data,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 exc_ack,
    output logic                 out_valid,
    output logic [REG_SIZE-1:0]  out_aluresult,
    output logic [REG_SIZE-1:0]  out_store_data,
    output logic [4:0]           out_dst,
    output logic                 out_regwrite,
    output logic                 out_memread,
    output logic                 out_memwrite,
    output logic                 redirect,
    output logic [ADDR_SIZE-1:0] redirect_pc,
    output logic                 exc_pending,
    output logic [ADDR_SIZE-1:0] epc
);

    typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_capture;
    logic                  w_eff_valid;
    logic                  w_raise;
    logic                  w_take;
    logic                  w_commit;

    logic                  r_valid;
    logic [REG_SIZE-1:0]   r_aluresult;
    logic [REG_SIZE-1:0]   r_store_data;
    logic [4:0]            r_dst;
    logic                  r_regwrite;
    logic                  r_memread;
    logic                  r_memwrite;
    logic                  r_redirect;
    logic [ADDR_SIZE-1:0]  r_redirect_pc;
    logic [ADDR_SIZE-1:0]  r_epc;

    // A new instruction is only latched when neither flushed nor stalled.
    assign w_capture   = ~flush & ~stall;
    // The ack edge already counts as idle, so an instruction arriving with the ack is kept.
    assign w_eff_valid = in_valid & ((r_state == S_IDLE) | exc_ack);
    assign w_raise     = w_capture & w_eff_valid & in_overflow;
    // Overflow outranks a taken branch: the faulting instruction must not redirect.
    assign w_take      = w_capture & w_eff_valid & in_branch & in_zero & ~in_overflow;
    // Side effects of an overflowing instruction are cancelled.
    assign w_commit    = w_eff_valid & ~in_overflow;

    // Exception FSM next state: a fresh overflow re-arms PEND even on the ack edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_raise) w_state_nxt = S_PEND;
            S_PEND: begin
                if (w_raise)      w_state_nxt = S_PEND;
                else if (exc_ack) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Exception state and EPC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_epc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_raise) r_epc <= in_pc;
        end
    end

    // Pipeline payload: reset > flush > stall > capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_aluresult   <= '0;
            r_store_data  <= '0;
            r_dst         <= '0;
            r_regwrite    <= 1'b0;
            r_memread     <= 1'b0;
            r_memwrite    <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_redirect <= 1'b0;
        end else if (stall) begin
            r_redirect <= 1'b0;
        end else begin
            r_valid      <= w_eff_valid;
            r_aluresult  <= in_aluresult;
            r_store_data <= in_store_data;
            r_dst        <= in_dst;
            r_regwrite   <= in_regwrite & w_commit;
            r_memread    <= in_memread  & w_commit;
            r_memwrite   <= in_memwrite & w_commit;
            r_redirect   <= w_take;
            if (w_take) r_redirect_pc <= in_new_pc;
        end
    end

    assign out_valid      = r_valid;
    assign out_aluresult  = r_aluresult;
    assign out_store_data = r_store_data;
    assign out_dst        = r_dst;
    assign out_regwrite   = r_regwrite;
    assign out_memread    = r_memread;
    assign out_memwrite   = r_memwrite;
    assign redirect       = r_redirect;
    assign redirect_pc    = r_redirect_pc;
    assign exc_pending    = (r_state == S_PEND);
    assign epc            = r_epc;

endmodule

// File: tb/tb_exmem_reg.sv
// Self-checking bench for exmem_reg: directed scenarios plus randomized traffic vs a reference model.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
// Every wait is a fixed number of clock cycles, so the run always terminates.
module tb_exmem_reg;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_zero, in_overflow;
    logic [31:0] in_aluresult, in_new_pc, in_pc, in_store_data;
    logic [4:0]  in_dst;
    logic        in_regwrite, in_memread, in_memwrite, in_branch;
    logic        stall, flush, exc_ack;
    logic        out_valid, out_regwrite, out_memread, out_memwrite, redirect, exc_pending;
    logic [31:0] out_aluresult, out_store_data, redirect_pc, epc;
    logic [4:0]  out_dst;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state: what the memory stage should be seeing
    logic        m_valid, m_rw, m_mr, m_mw, m_redir, m_pend;
    logic [31:0] m_alu, m_sd, m_rpc, m_epc;
    logic [4:0]  m_dst;

    always #5 clk = ~clk;

    exmem_reg #(.REG_SIZE(32), .ADDR_SIZE(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_aluresult(in_aluresult),
        .in_zero(in_zero), .in_overflow(in_overflow), .in_new_pc(in_new_pc), .in_pc(in_pc),
        .in_dst(in_dst), .in_regwrite(in_regwrite), .in_memread(in_memread),
        .in_memwrite(in_memwrite), .in_branch(in_branch), .in_store_data(in_store_data),
        .stall(stall), .flush(flush), .exc_ack(exc_ack),
        .out_valid(out_valid), .out_aluresult(out_aluresult), .out_store_data(out_store_data),
        .out_dst(out_dst), .out_regwrite(out_regwrite), .out_memread(out_memread),
        .out_memwrite(out_memwrite), .redirect(redirect), .redirect_pc(redirect_pc),
        .exc_pending(exc_pending), .epc(epc)
    );

    // Apply the architectural rules for one clock edge to the model.
    task automatic model_step();
        logic accepted, faulted;
        if (reset) begin
            {m_valid, m_rw, m_mr, m_mw, m_redir, m_pend} = '0;
            m_alu = 0; m_sd = 0; m_rpc = 0; m_epc = 0; m_dst = 0;
        end else begin
            // an instruction counts if valid and no exception is outstanding after this edge's ack
            accepted = in_valid && (!m_pend || exc_ack);
            if (flush) begin
                m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_redir = 0;
                if (exc_ack) m_pend = 0;
            end else if (stall) begin
                m_redir = 0;
                if (exc_ack) m_pend = 0;
            end else begin
                faulted = accepted && in_overflow;
                m_valid = accepted;
                m_alu = in_aluresult; m_sd = in_store_data; m_dst = in_dst;
                m_rw = in_regwrite && accepted && !in_overflow;
                m_mr = in_memread  && accepted && !in_overflow;
                m_mw = in_memwrite && accepted && !in_overflow;
                m_redir = accepted && in_branch && in_zero && !faulted;
                if (m_redir) m_rpc = in_new_pc;
                if (faulted) begin
                    m_pend = 1; m_epc = in_pc;
                end else if (exc_ack) begin
                    m_pend = 0;
                end
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; in_valid = 0; in_zero = 0; in_overflow = 0; in_aluresult = 0;
        in_new_pc = 0; in_pc = 0; in_store_data = 0; in_dst = 0; in_regwrite = 0;
        in_memread = 0; in_memwrite = 0; in_branch = 0; stall = 0; flush = 0; exc_ack = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; stall = 1; flush = 1; exc_ack = 1; in_valid = 1; in_overflow = 1;
        cycle();
        n_cmp++;
        if ({out_valid, out_regwrite, out_memread, out_memwrite, redirect, exc_pending} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 000000",
                {out_valid, out_regwrite, out_memread, out_memwrite, redirect, exc_pending});
        end
        n_cmp++;
        if ({out_aluresult, out_store_data, out_dst, redirect_pc, epc} !== '0) begin
            n_err++; $display("FAIL reset_data: alu=%h sd=%h dst=%0d rpc=%h epc=%h want all 0",
                out_aluresult, out_store_data, out_dst, redirect_pc, epc);
        end
        idle_inputs();
    endtask

    task automatic test_capture();
        idle_inputs();
        in_valid = 1; in_aluresult = 32'h0000_1234; in_dst = 5; in_regwrite = 1;
        in_store_data = 32'hCAFE_0001;
        cycle();
        n_cmp++;
        if (out_valid !== 1'b1 || out_aluresult !== 32'h1234 || out_dst !== 5'd5 || out_regwrite !== 1'b1) begin
            n_err++; $display("FAIL capture: v=%b alu=%h dst=%0d rw=%b want 1 00001234 5 1",
                out_valid, out_aluresult, out_dst, out_regwrite);
        end
        n_cmp++;
        if (out_store_data !== 32'hCAFE_0001 || out_memread !== 1'b0 || out_memwrite !== 1'b0) begin
            n_err++; $display("FAIL capture_sd: sd=%h mr=%b mw=%b want cafe0001 0 0",
                out_store_data, out_memread, out_memwrite);
        end
        idle_inputs();
    endtask

    task automatic test_branch();
        idle_inputs();
        in_valid = 1; in_branch = 1; in_zero = 1; in_new_pc = 32'h40;
        cycle();
        n_cmp++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h40) begin
            n_err++; $display("FAIL branch_taken: redir=%b pc=%h want 1 00000040", redirect, redirect_pc);
        end
        idle_inputs();
        cycle();
        n_cmp++;
        if (redirect !== 1'b0 || redirect_pc !== 32'h40) begin
            n_err++; $display("FAIL branch_pulse: redir=%b pc=%h want 0 00000040", redirect, redirect_pc);
        end
        in_valid = 1; in_branch = 1; in_zero = 0; in_new_pc = 32'h80;
        cycle();
        n_cmp++;
        if (redirect !== 1'b0 || redirect_pc !== 32'h40) begin
            n_err++; $display("FAIL branch_not_taken: redir=%b pc=%h want 0 00000040", redirect, redirect_pc);
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        idle_inputs();
        in_valid = 1; in_aluresult = 32'hAAAA; in_dst = 7; in_regwrite = 1;
        in_branch = 1; in_zero = 1; in_new_pc = 32'h44;
        cycle();
        n_cmp++;
        if (redirect !== 1'b1) begin
            n_err++; $display("FAIL stall_pre_redir: got %b want 1", redirect);
        end
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            in_aluresult = $urandom; in_dst = 5'($urandom); in_new_pc = $urandom;
            cycle();
            n_cmp++;
            if (out_valid !== 1'b1 || out_aluresult !== 32'hAAAA || out_dst !== 5'd7 ||
                out_regwrite !== 1'b1 || redirect !== 1'b0 || redirect_pc !== 32'h44) begin
                n_err++; $display("FAIL stall_hold[%0d]: v=%b alu=%h dst=%0d rw=%b redir=%b rpc=%h want 1 0000aaaa 7 1 0 00000044",
                    i, out_valid, out_aluresult, out_dst, out_regwrite, redirect, redirect_pc);
            end
        end
        stall = 0; in_branch = 0; in_aluresult = 32'h5555; in_dst = 9;
        cycle();
        n_cmp++;
        if (out_aluresult !== 32'h5555 || out_dst !== 5'd9) begin
            n_err++; $display("FAIL stall_release: alu=%h dst=%0d want 00005555 9", out_aluresult, out_dst);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        idle_inputs();
        in_valid = 1; in_regwrite = 1;
        cycle();
        flush = 1; in_memwrite = 1; in_branch = 1; in_zero = 1; in_new_pc = 32'h99;
        cycle();
        n_cmp++;
        if (out_valid !== 1'b0 || out_regwrite !== 1'b0 || out_memwrite !== 1'b0 || redirect !== 1'b0) begin
            n_err++; $display("FAIL flush: v=%b rw=%b mw=%b redir=%b want 0 0 0 0",
                out_valid, out_regwrite, out_memwrite, redirect);
        end
        idle_inputs();
    endtask

    task automatic test_overflow();
        idle_inputs();
        in_valid = 1; in_overflow = 1; in_pc = 32'h100; in_regwrite = 1;
        in_branch = 1; in_zero = 1; in_new_pc = 32'hBAD0;
        cycle();
        n_cmp++;
        if (out_regwrite !== 1'b0 || exc_pending !== 1'b1 || epc !== 32'h100 || redirect !== 1'b0) begin
            n_err++; $display("FAIL ovf_raise: rw=%b pend=%b epc=%h redir=%b want 0 1 00000100 0",
                out_regwrite, exc_pending, epc, redirect);
        end
        in_overflow = 0; in_branch = 0; in_pc = 32'h200;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if (out_valid !== 1'b0 || out_regwrite !== 1'b0 || epc !== 32'h100 || exc_pending !== 1'b1) begin
                n_err++; $display("FAIL ovf_bubble[%0d]: v=%b rw=%b epc=%h pend=%b want 0 0 00000100 1",
                    i, out_valid, out_regwrite, epc, exc_pending);
            end
        end
        in_valid = 0; exc_ack = 1;
        cycle();
        n_cmp++;
        if (exc_pending !== 1'b0) begin
            n_err++; $display("FAIL ovf_ack: pend=%b want 0", exc_pending);
        end
        exc_ack = 0; in_valid = 1; in_pc = 32'h300; in_aluresult = 32'h77;
        cycle();
        n_cmp++;
        if (out_valid !== 1'b1 || out_regwrite !== 1'b1 || out_aluresult !== 32'h77 || epc !== 32'h100) begin
            n_err++; $display("FAIL ovf_resume: v=%b rw=%b alu=%h epc=%h want 1 1 00000077 00000100",
                out_valid, out_regwrite, out_aluresult, epc);
        end
        idle_inputs();
    endtask

    task automatic test_reset_pending();
        idle_inputs();
        in_valid = 1; in_overflow = 1; in_pc = 32'h500; in_aluresult = 32'h1;
        cycle();
        n_cmp++;
        if (exc_pending !== 1'b1) begin
            n_err++; $display("FAIL rstp_setup: pend=%b want 1", exc_pending);
        end
        in_overflow = 0; reset = 1; stall = 1;
        cycle();
        n_cmp++;
        if ({out_valid, out_regwrite, out_memread, out_memwrite, redirect, exc_pending} !== 6'b0 ||
            {out_aluresult, out_store_data, out_dst, redirect_pc, epc} !== '0) begin
            n_err++; $display("FAIL rstp_clear: v=%b pend=%b alu=%h epc=%h want all 0",
                out_valid, exc_pending, out_aluresult, epc);
        end
        reset = 0; stall = 0; in_regwrite = 1;
        cycle();
        n_cmp++;
        if (out_valid !== 1'b1 || out_regwrite !== 1'b1 || exc_pending !== 1'b0) begin
            n_err++; $display("FAIL rstp_idle: v=%b rw=%b pend=%b want 1 1 0", out_valid, out_regwrite, exc_pending);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(39) == 0);
            flush = ($urandom_range(7) == 0);
            stall = ($urandom_range(4) == 0);
            exc_ack = ($urandom_range(3) == 0);
            in_overflow = ($urandom_range(5) == 0);
            in_valid = ($urandom_range(3) != 0);
            in_zero = 1'($urandom); in_branch = 1'($urandom);
            in_regwrite = 1'($urandom); in_memread = 1'($urandom); in_memwrite = 1'($urandom);
            in_aluresult = $urandom; in_store_data = $urandom; in_new_pc = $urandom;
            in_pc = $urandom; in_dst = 5'($urandom);
            cycle();
            n_cmp++;
            if ({out_valid, out_regwrite, out_memread, out_memwrite, redirect, exc_pending} !==
                {m_valid, m_rw, m_mr, m_mw, m_redir, m_pend}) begin
                n_err++; $display("FAIL rand_ctrl[%0d]: v/rw/mr/mw/redir/pend got %b want %b", i,
                    {out_valid, out_regwrite, out_memread, out_memwrite, redirect, exc_pending},
                    {m_valid, m_rw, m_mr, m_mw, m_redir, m_pend});
            end
            n_cmp++;
            if (out_aluresult !== m_alu || out_store_data !== m_sd || out_dst !== m_dst) begin
                n_err++; $display("FAIL rand_data[%0d]: alu=%h sd=%h dst=%0d want %h %h %0d", i,
                    out_aluresult, out_store_data, out_dst, m_alu, m_sd, m_dst);
            end
            n_cmp++;
            if (redirect_pc !== m_rpc || epc !== m_epc) begin
                n_err++; $display("FAIL rand_pc[%0d]: rpc=%h epc=%h want %h %h", i,
                    redirect_pc, epc, m_rpc, m_epc);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        #1;
        test_reset();
        test_capture();
        test_branch();
        test_stall();
        test_flush();
        test_overflow();
        test_reset_pending();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
